// File: rtl/regfile_pkg.sv
// Shared constants and address helpers for the multi-port register file.
// Imported by the storage top and its read-port slices.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    // An address holds real state only if in range and not the hardwired zero.
    function automatic logic addr_valid(
        input logic [31:0] addr,
        input int          depth,
        input logic        zero_reg
    );
        return (addr < 32'(depth)) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: write bypass, range/zero masking and hold on !re.
// Pre- and post-update register/pending values come from the storage top.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rf_val,
    input  logic              pend_pre,
    input  logic              pend_post,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd,
    output logic              rd_pend
);

    logic [DATA_W-1:0] rd_d, rd_q;
    logic              rd_pend_d, rd_pend_q;
    logic [DATA_W-1:0] data;
    logic              pend;
    logic              hit0, hit1;

    always_comb begin
        hit0 = we[0] && (wa0 == ra);
        hit1 = we[1] && (wa1 == ra);
        data = rf_val;
        pend = pend_pre;
        if (BYPASS != 0) begin
            // Port 1 has write priority, so it also wins the bypass.
            if (hit1) begin
                data = wd1;
            end else if (hit0) begin
                data = wd0;
            end
            pend = pend_post;
        end
        if (!addr_valid(32'(ra), DEPTH, ZERO_REG != 0)) begin
            data = '0;
            pend = 1'b0;
        end
        rd_d      = rd_q;
        rd_pend_d = rd_pend_q;
        if (re) begin
            rd_d      = data;
            rd_pend_d = pend;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q      <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign rd      = rd_q;
    assign rd_pend = rd_pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write lanes, reservation
// scoreboard, NUM_RD registered read ports and a read-first debug port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int ADDR_W  = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      wa,
    input  logic [2*DATA_W-1:0]      wd,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    logic [DATA_W-1:0] rf_q   [DEPTH];
    logic [DATA_W-1:0] rf_d   [DEPTH];
    logic              pend_q [DEPTH];
    logic              pend_d [DEPTH];
    logic [DATA_W-1:0] dbg_data_d, dbg_data_q;

    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              wv0, wv1, rv;

    assign wa0 = wa[0 +: ADDR_W];
    assign wa1 = wa[ADDR_W +: ADDR_W];
    assign wd0 = wd[0 +: DATA_W];
    assign wd1 = wd[DATA_W +: DATA_W];

    assign wv0 = we[0] && addr_valid(32'(wa0), DEPTH, ZERO_REG != 0);
    assign wv1 = we[1] && addr_valid(32'(wa1), DEPTH, ZERO_REG != 0);
    assign rv  = rsv_en && addr_valid(32'(rsv_addr), DEPTH, ZERO_REG != 0);

    // Order matters: port 1 overrides port 0, reserve overrides both clears.
    always_comb begin
        rf_d   = rf_q;
        pend_d = pend_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (wv0 && (wa0 == ADDR_W'(j))) begin
                rf_d[j]   = wd0;
                pend_d[j] = 1'b0;
            end
            if (wv1 && (wa1 == ADDR_W'(j))) begin
                rf_d[j]   = wd1;
                pend_d[j] = 1'b0;
            end
            if (rv && (rsv_addr == ADDR_W'(j))) begin
                pend_d[j] = 1'b1;
            end
        end
    end

    always_comb begin
        dbg_data_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (dbg_addr == ADDR_W'(j)) begin
                dbg_data_d = rf_q[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < DEPTH; j++) begin
                rf_q[j]   <= '0;
                pend_q[j] <= 1'b0;
            end
            dbg_data_q <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                rf_q[j]   <= rf_d[j];
                pend_q[j] <= pend_d[j];
            end
            dbg_data_q <= dbg_data_d;
        end
    end

    assign dbg_data = dbg_data_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_i;
        logic [DATA_W-1:0] rf_val;
        logic              p_pre;
        logic              p_post;

        assign ra_i = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            rf_val = '0;
            p_pre  = 1'b0;
            p_post = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ra_i == ADDR_W'(j)) begin
                    rf_val = rf_q[j];
                    p_pre  = pend_q[j];
                    p_post = pend_d[j];
                end
            end
        end

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk       (clk),
            .rstn      (rstn),
            .re        (re[i]),
            .ra        (ra_i),
            .rf_val    (rf_val),
            .pend_pre  (p_pre),
            .pend_post (p_post),
            .we        (we),
            .wa0       (wa0),
            .wa1       (wa1),
            .wd0       (wd0),
            .wd1       (wd1),
            .rd        (rd[i*DATA_W +: DATA_W]),
            .rd_pend   (rd_pend[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: write-first/32-entry and read-first/24-entry instances
// driven by the same stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rstn;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  dbg_addr;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  pd_a, pd_b;
    logic [31:0] dbg_a, dbg_b;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_mp u_a (
        .clk (clk), .rstn (rstn), .re (re), .ra (ra),
        .rd (rd_a), .rd_pend (pd_a), .we (we), .wa (wa), .wd (wd),
        .rsv_en (rsv_en), .rsv_addr (rsv_addr),
        .dbg_addr (dbg_addr), .dbg_data (dbg_a)
    );

    regfile_mp #(.DEPTH (24), .BYPASS (0)) u_b (
        .clk (clk), .rstn (rstn), .re (re), .ra (ra),
        .rd (rd_b), .rd_pend (pd_b), .we (we), .wa (wa), .wd (wd),
        .rsv_en (rsv_en), .rsv_addr (rsv_addr),
        .dbg_addr (dbg_addr), .dbg_data (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re     = 2'b00;
        we     = 2'b00;
        rsv_en = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        ra = '0; wa = '0; wd = '0;
        rsv_addr = '0;
        dbg_addr = 5'd5;
        #3;
        chk("rst_rd_a", rd_a[31:0], 32'h0);
        chk("rst_rd_b", rd_b[63:32], 32'h0);
        chk("rst_pend", {28'h0, pd_a, pd_b}, 32'h0);
        chk("rst_dbg", dbg_a, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc();

        // basic write then read on port 1
        we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF;
        cyc();
        idle(); re = 2'b10; ra[9:5] = 5'd5;
        cyc();
        chk("basic_a", rd_a[63:32], 32'hDEADBEEF);
        chk("basic_b", rd_b[63:32], 32'hDEADBEEF);
        chk("dbg_a", dbg_a, 32'hDEADBEEF);
        chk("dbg_b", dbg_b, 32'hDEADBEEF);

        // same-cycle write and read of r7
        idle(); re = 2'b01; ra[4:0] = 5'd7;
        we = 2'b01; wa[4:0] = 5'd7; wd[31:0] = 32'h12345678;
        cyc();
        chk("byp_a", rd_a[31:0], 32'h12345678);
        chk("byp_b_old", rd_b[31:0], 32'h0);
        idle(); re = 2'b01; ra[4:0] = 5'd7;
        cyc();
        chk("byp_b_new", rd_b[31:0], 32'h12345678);

        // write collision, port 1 wins
        idle(); we = 2'b11;
        wa = {5'd3, 5'd3}; wd = {32'h5555, 32'hAAAA};
        cyc();
        idle(); re = 2'b01; ra[4:0] = 5'd3;
        cyc();
        chk("coll_a", rd_a[31:0], 32'h5555);
        chk("coll_b", rd_b[31:0], 32'h5555);

        // zero register, with reserve in the same cycle
        idle(); we = 2'b01; wa[4:0] = 5'd0; wd[31:0] = 32'hFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        re = 2'b01; ra[4:0] = 5'd0;
        cyc();
        chk("zero_a", rd_a[31:0], 32'h0);
        chk("zero_pa", {31'h0, pd_a[0]}, 32'h0);
        idle(); re = 2'b01; ra[4:0] = 5'd0;
        cyc();
        chk("zero_b", rd_b[31:0], 32'h0);
        chk("zero_pb", {31'h0, pd_b[0]}, 32'h0);

        // r30 exists at depth 32, not at depth 24
        idle(); we = 2'b01; wa[4:0] = 5'd30; wd[31:0] = 32'hCAFE;
        cyc();
        idle(); re = 2'b01; ra[4:0] = 5'd30;
        cyc();
        chk("r30_a", rd_a[31:0], 32'hCAFE);
        chk("r30_b", rd_b[31:0], 32'h0);

        // scoreboard on r9 via port 1
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
        re = 2'b10; ra[9:5] = 5'd9;
        cyc();
        chk("rsv_pa", {31'h0, pd_a[1]}, 32'h1);
        chk("rsv_pb", {31'h0, pd_b[1]}, 32'h0);
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
        we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h99;
        re = 2'b10; ra[9:5] = 5'd9;
        cyc();
        chk("rsvw_pa", {31'h0, pd_a[1]}, 32'h1);
        chk("rsvw_da", rd_a[63:32], 32'h99);
        chk("rsvw_pb", {31'h0, pd_b[1]}, 32'h1);
        chk("rsvw_db", rd_b[63:32], 32'h0);
        idle(); we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h77;
        re = 2'b10; ra[9:5] = 5'd9;
        cyc();
        chk("clr_pa", {31'h0, pd_a[1]}, 32'h0);
        chk("clr_da", rd_a[63:32], 32'h77);
        chk("clr_pb", {31'h0, pd_b[1]}, 32'h1);
        chk("clr_db", rd_b[63:32], 32'h99);
        idle(); re = 2'b10; ra[9:5] = 5'd9;
        cyc();
        chk("clr_pb2", {31'h0, pd_b[1]}, 32'h0);
        chk("clr_db2", rd_b[63:32], 32'h77);

        // re low holds the previous capture
        idle(); ra[9:5] = 5'd5;
        cyc();
        chk("hold_a", rd_a[63:32], 32'h77);

        // asynchronous reset while r4 is on rd
        idle(); we = 2'b01; wa[4:0] = 5'd4; wd[31:0] = 32'h1;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        dbg_addr = 5'd4;
        cyc();
        idle(); re = 2'b01; ra[4:0] = 5'd4;
        cyc();
        chk("pre_rst_rd", rd_a[31:0], 32'h1);
        chk("pre_rst_pd", {31'h0, pd_a[0]}, 32'h1);
        chk("pre_rst_dbg", dbg_a, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_rd_a", rd_a[31:0], 32'h0);
        chk("arst_rd_b", rd_b[31:0], 32'h0);
        chk("arst_dbg", dbg_a, 32'h0);
        chk("arst_pend", {28'h0, pd_a, pd_b}, 32'h0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        re = 2'b01; ra[4:0] = 5'd4;
        @(posedge clk);
        #1;
        chk("post_rst_rd", rd_a[31:0], 32'h0);
        chk("post_rst_pd", {31'h0, pd_a[0]}, 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath, successor to the single-write synchronous register file. Adds configurable width, depth and read-port count; two write ports with fixed priority; optional write-to-read bypass; optional hardwired zero register; a per-register pending scoreboard; and a registered debug read port. Sits between decode (reads and reservations) and writeback (two retire lanes).

## Interface
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers, at least 2; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width (derived).
- NUM_RD, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: 1 means address 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1: 1 means write-first (same-cycle write is visible on the read result); 0 means read-first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- re  in  NUM_RD  per-port read enable.
- ra  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  registered read data, packed the same way as ra.
- rd_pend  out  NUM_RD  registered pending flag of the register read on each port.
- we  in  2  write enables, one per write port.
- wa  in  2*ADDR_W  write addresses.
- wd  in  2*DATA_W  write data.
- rsv_en  in  1  reserve a register (marks it pending).
- rsv_addr  in  ADDR_W  register to reserve.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  registered debug read data.

## Operation
- Storage is rf[DEPTH] of DATA_W bits, plus pend[DEPTH] of 1 bit.
- Write:
  - On a rising edge with we[k]=1, rf[wa_k] <= wd_k and pend[wa_k] <= 0.
  - If both ports write the same address, port 1 wins for the data. Pending is cleared either way.
- Ignored writes:
  - Writes to addresses >= DEPTH are ignored.
  - Writes to address 0 are ignored when ZERO_REG=1.
- Reserve:
  - rsv_en=1 sets pend[rsv_addr] <= 1.
  - A reserve and a write to the same address in the same cycle leave pend=1 (reserve wins).
  - Reserves to addresses >= DEPTH, or to 0 when ZERO_REG=1, are ignored.
- Read port i:
  - When re[i]=1, the port captures rf[ra_i] into rd_i and the pending flag into rd_pend_i.
  - When re[i]=0, rd_i and rd_pend_i hold their previous values.
- BYPASS=1:
  - Captured data is the post-write value: port 1's wd if port 1 hits ra_i, else port 0's wd if it hits, else rf.
  - Captured pending flag is the post-update pend value.
- BYPASS=0:
  - Captured data and pending flag are the pre-edge values.
- Out-of-range and zero reads:
  - Reading an address >= DEPTH returns 0 and pending 0.
  - Reading address 0 with ZERO_REG=1 returns 0 and pending 0.
- Debug port: dbg_data <= rf[dbg_addr] every cycle, always read-first, no enable.

## Timing
- Read latency is 1 cycle: address presented at edge N, data valid after edge N.
- Write is visible to a read issued at a later edge; with BYPASS=1 it is also visible to a read issued at the same edge.
- Reserve is visible through rd_pend at the next read edge; with BYPASS=1 it is visible at the same edge.
- No handshake and no stalls; every port accepts one operation per cycle.
- Reset (rstn=0, asynchronous, applies mid-operation at any time):
  - All rf entries, pend, rd, rd_pend and dbg_data go to 0 immediately.
  - Writes and reserves are suppressed while reset is held.
  - The first edge after rstn rises is a normal operating edge.

## Structure
- Shared package regfile_pkg: default DATA_W/DEPTH constants and a function addr_valid(addr, DEPTH, ZERO_REG).
- One sub-module, regfile_rd_port: a single registered read port containing the bypass mux, the out-of-range/zero masking and the hold-on-!re logic. It is instantiated NUM_RD times in a generate loop.
- Storage and pending array stay in the top level.

## Test plan
- Reset and basic access: reset, then write port 0 to r5=0xDEADBEEF, then read r5 on port 1 next cycle -> rd1=0xDEADBEEF after 1 cycle; all outputs were 0 during reset.
- Bypass: same-cycle write r7=0x12345678 and read r7:
  - BYPASS=1 -> rd=0x12345678.
  - BYPASS=0 -> rd=0 (old value), then 0x12345678 on the following read.
- Write collision: both ports write r3 (port 0 0xAAAA, port 1 0x5555) -> r3 reads 0x5555.
- Zero register and range: write r0=0xFFFF, then read r0 -> 0 with pending 0; with DEPTH=24, write r30 -> ignored, read r30 -> 0.
- Scoreboard: reserve r9 -> rd_pend=1; reserve r9 and write r9 in the same cycle -> still 1; write r9 alone -> rd_pend=0.
- Reset mid-operation: assert rstn=0 between edges while r4=0x1 is held on rd -> rd, dbg_data and pend go to 0 without waiting for a clock edge; a read of r4 after release -> 0.
